// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI register-file responder.
package spi_slave_pkg;

  // Register addresses with special behaviour
  localparam logic [5:0] ERROR_REG   = 6'h06;
  localparam logic [5:0] FIFO_DATA   = 6'h09;
  localparam logic [5:0] FIFO_LEVEL  = 6'h0A;
  localparam logic [5:0] VERSION_REG = 6'h37;

  // BufferOvfl flag position inside ERROR_REG
  localparam int BUFOVFL_BIT = 4;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } spi_state_e;

  // Registers the local host may write directly; FIFO and version are SPI/fixed only
  function automatic logic host_writable(input logic [5:0] a);
    return !((a == FIFO_DATA) || (a == FIFO_LEVEL) || (a == VERSION_REG));
  endfunction

endpackage

// File: rtl/spi_slv_fifo.sv
// Synchronous byte FIFO behind FIFODataReg. Pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module spi_slv_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic [6:0] level,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] cnt;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign cnt     = wptr - rptr;
  assign level   = 7'(cnt);
  // An empty FIFO reads as 0x00 so a pop of nothing returns a clean byte
  assign head    = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // Pointer update: flush wins, otherwise independent push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder speaking the MFRC522 register protocol onto a 64x8
// register file with a byte FIFO at FIFODataReg. All SPI pins are
// oversampled in axi_aclk.
//
// Handshakes: there is no valid/ready flow control here. host_we is a
// one-cycle write strobe always accepted; host_rdata is a registered read of
// host_addr with one cycle of latency; evt_valid is a one-cycle pulse with
// evt_addr/evt_data valid in the same cycle and no back-pressure.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] VERSION     = 8'h92
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [5:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       evt_valid,
  output logic [5:0] evt_addr,
  output logic [7:0] evt_data,
  output spi_state_e dbg_state
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic cs_s, sck_s, mosi_s;
  logic cs_q, sck_q;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  spi_state_e state_q, state_d;
  logic [2:0] bitcnt;
  logic [7:0] shift_in;
  logic [7:0] rx_byte;
  logic [7:0] miso_sh;
  logic [5:0] addr_q;
  logic       byte_done;
  logic       addr_load;
  logic       spi_we;
  logic       rd_load;
  logic [5:0] rd_addr;

  logic [7:0] regs [64];

  logic       fifo_push, fifo_pop, fifo_flush;
  logic [7:0] fifo_head;
  logic [6:0] fifo_level;
  logic       fifo_full, fifo_empty;

  // Synchronizers; CS idles high so its chain resets to ones
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_cs_n);
      sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(spi_sck);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      cs_q      <= cs_s;
      sck_q     <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;
  assign sck_fall = sck_q & ~sck_s;

  assign rx_byte   = {shift_in[6:0], mosi_s};
  assign byte_done = sck_rise && (bitcnt == 3'd7);
  assign dbg_state = state_q;
  // Pad enable follows the synchronized chip select
  assign spi_miso_oe = ~cs_s;

  // Read mux shared by the SPI read path and the host read port
  function automatic logic [7:0] read_mux(input logic [5:0] a);
    case (a)
      FIFO_DATA:  return fifo_head;
      FIFO_LEVEL: return {1'b0, fifo_level};
      default:    return regs[a];
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state and per-byte control strobes; CS rise aborts from any state
  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    spi_we    = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = rx_byte[6:1];
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = ADDR;
      end
      ADDR: begin
        if (byte_done) begin
          if (rx_byte[7]) begin
            state_d = RDATA;
            rd_load = 1'b1;
          end else begin
            state_d   = WDATA;
            addr_load = 1'b1;
          end
        end
      end
      WDATA: begin
        if (byte_done) spi_we = 1'b1;
      end
      RDATA: begin
        if (byte_done) rd_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && cs_rise) begin
      state_d   = IDLE;
      addr_load = 1'b0;
      spi_we    = 1'b0;
      rd_load   = 1'b0;
    end
  end

  // Bit counter, MOSI shift-in and latched write address
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      bitcnt   <= '0;
      shift_in <= '0;
      addr_q   <= '0;
    end else begin
      if (cs_fall) begin
        bitcnt <= '0;
      end else if (sck_rise && (state_q != IDLE)) begin
        bitcnt   <= bitcnt + 3'd1;
        shift_in <= rx_byte;
      end
      if (addr_load) addr_q <= rx_byte[6:1];
    end
  end

  // MISO shifter: loaded on a read byte, shifted out MSB first on SCK fall
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      miso_sh  <= '0;
      spi_miso <= 1'b0;
    end else if (cs_fall || (state_d == IDLE)) begin
      miso_sh  <= '0;
      spi_miso <= 1'b0;
    end else if (rd_load) begin
      miso_sh <= read_mux(rd_addr);
    end else if (sck_fall) begin
      spi_miso <= miso_sh[7];
      miso_sh  <= {miso_sh[6:0], 1'b0};
    end
  end

  assign fifo_push  = spi_we && (addr_q == FIFO_DATA);
  assign fifo_flush = spi_we && (addr_q == FIFO_LEVEL) && rx_byte[7];
  assign fifo_pop   = rd_load && (rd_addr == FIFO_DATA) && !fifo_empty;

  spi_slv_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (rx_byte),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register file: host write first so a same-cycle SPI write overrides it
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[VERSION_REG] <= VERSION;
    end else begin
      if (host_we && host_writable(host_addr)) regs[host_addr] <= host_wdata;
      if (spi_we) begin
        case (addr_q)
          FIFO_DATA: begin
            if (fifo_full) regs[ERROR_REG][BUFOVFL_BIT] <= 1'b1;
          end
          FIFO_LEVEL: begin
            if (rx_byte[7]) regs[ERROR_REG][BUFOVFL_BIT] <= 1'b0;
          end
          VERSION_REG: ;
          default: regs[addr_q] <= rx_byte;
        endcase
      end
    end
  end

  // Registered host read port
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) host_rdata <= '0;
    else            host_rdata <= read_mux(host_addr);
  end

  // Write event pulse, one cycle after the data byte completes
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      evt_valid <= 1'b0;
      evt_addr  <= '0;
      evt_data  <= '0;
    end else begin
      evt_valid <= spi_we;
      if (spi_we) begin
        evt_addr <= addr_q;
        evt_data <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: SPI mode-0 master tasks, host port
// tasks and one task per scenario with inline comparisons.
module tb_spi_slave_regfile;
  import spi_slave_pkg::*;

  // Clock / reset
  logic axi_aclk = 1'b0;
  logic axi_areset = 1'b1;
  always #5 axi_aclk = ~axi_aclk;

  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [5:0] host_addr = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       evt_valid;
  logic [5:0] evt_addr;
  logic [7:0] evt_data;
  spi_state_e dbg_state;

  spi_slave_regfile #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (16),
    .VERSION     (8'h92)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_areset  (axi_areset),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .evt_valid   (evt_valid),
    .evt_addr    (evt_addr),
    .evt_data    (evt_data),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  // Event monitor
  int         evt_cnt = 0;
  logic [5:0] evt_last_addr = '0;
  logic [7:0] evt_last_data = '0;
  always @(posedge axi_aclk) begin
    if (evt_valid === 1'b1) begin
      evt_cnt++;
      evt_last_addr = evt_addr;
      evt_last_data = evt_data;
    end
  end

  // Driver tasks (SCK half period 80 ns = 8 aclk cycles)
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80;
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      #80;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_txn(input int n);
    logic [7:0] r;
    spi_cs_n = 1'b0;
    #80;
    for (int k = 0; k < n; k++) begin
      spi_byte(tx_buf[k], r);
      rx_buf[k] = r;
    end
    #80;
    spi_cs_n = 1'b1;
    #160;
  endtask

  task automatic spi_rd2(input logic [7:0] cmd);
    tx_buf[0] = cmd;
    tx_buf[1] = 8'h00;
    spi_txn(2);
  endtask

  task automatic spi_wr2(input logic [7:0] cmd, input logic [7:0] d);
    tx_buf[0] = cmd;
    tx_buf[1] = d;
    spi_txn(2);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge axi_aclk);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge axi_aclk);
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge axi_aclk);
    host_addr = a;
    @(negedge axi_aclk);
    d = host_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #30;
    if (spi_miso !== 1'b0) begin $display("FAIL reset_miso got=%b exp=0", spi_miso); bad++; end
    total++;
    if (spi_miso_oe !== 1'b0) begin $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); bad++; end
    total++;
    if (host_rdata !== 8'h00) begin $display("FAIL reset_rdata got=%h exp=00", host_rdata); bad++; end
    total++;
    if (evt_valid !== 1'b0) begin $display("FAIL reset_evt got=%b exp=0", evt_valid); bad++; end
    total++;
    axi_areset = 1'b0;
    #50;
    host_read(6'h37, d);
    if (d !== 8'h92) begin $display("FAIL reset_version got=%h exp=92", d); bad++; end
    total++;
    host_read(6'h01, d);
    if (d !== 8'h00) begin $display("FAIL reset_reg01 got=%h exp=00", d); bad++; end
    total++;
  endtask

  task automatic test_write_read();
    evt_cnt = 0;
    spi_wr2(8'h02, 8'h11);
    if (evt_cnt !== 1) begin $display("FAIL wr_evt_cnt got=%0d exp=1", evt_cnt); bad++; end
    total++;
    if (evt_last_addr !== 6'h01 || evt_last_data !== 8'h11) begin
      $display("FAIL wr_evt_fields got=%h/%h exp=01/11", evt_last_addr, evt_last_data); bad++;
    end
    total++;
    spi_rd2(8'h82);
    if (rx_buf[0] !== 8'h00) begin $display("FAIL rd_addr_byte got=%h exp=00", rx_buf[0]); bad++; end
    total++;
    if (rx_buf[1] !== 8'h11) begin $display("FAIL rd_reg01 got=%h exp=11", rx_buf[1]); bad++; end
    total++;
  endtask

  task automatic test_version();
    spi_rd2(8'hEE);
    if (rx_buf[1] !== 8'h92) begin $display("FAIL version_rd got=%h exp=92", rx_buf[1]); bad++; end
    total++;
    spi_wr2(8'h6E, 8'h55);
    spi_rd2(8'hEE);
    if (rx_buf[1] !== 8'h92) begin $display("FAIL version_ro got=%h exp=92", rx_buf[1]); bad++; end
    total++;
  endtask

  task automatic test_burst();
    tx_buf[0] = 8'h12; tx_buf[1] = 8'hA0; tx_buf[2] = 8'hA1; tx_buf[3] = 8'hA2;
    spi_txn(4);
    spi_rd2(8'h94);
    if (rx_buf[1] !== 8'h03) begin $display("FAIL burst_level got=%h exp=03", rx_buf[1]); bad++; end
    total++;
    tx_buf[0] = 8'h92; tx_buf[1] = 8'h92; tx_buf[2] = 8'h92; tx_buf[3] = 8'h00;
    spi_txn(4);
    if (rx_buf[1] !== 8'hA0 || rx_buf[2] !== 8'hA1 || rx_buf[3] !== 8'hA2) begin
      $display("FAIL burst_pop got=%h %h %h exp=a0 a1 a2", rx_buf[1], rx_buf[2], rx_buf[3]); bad++;
    end
    total++;
    spi_rd2(8'h94);
    if (rx_buf[1] !== 8'h00) begin $display("FAIL burst_level_after got=%h exp=00", rx_buf[1]); bad++; end
    total++;
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] r;
    spi_cs_n = 1'b0;
    #80;
    spi_byte(8'h12, r);
    for (int k = 0; k < 17; k++) spi_byte(8'(8'h30 + k), r);
    #80;
    spi_cs_n = 1'b1;
    #160;
    spi_rd2(8'h94);
    if (rx_buf[1] !== 8'h10) begin $display("FAIL ovf_level got=%h exp=10", rx_buf[1]); bad++; end
    total++;
    spi_rd2(8'h8C);
    if (rx_buf[1] !== 8'h10) begin $display("FAIL ovf_flag got=%h exp=10", rx_buf[1]); bad++; end
    total++;
    host_read(6'h09, d);
    if (d !== 8'h30) begin $display("FAIL ovf_host_head got=%h exp=30", d); bad++; end
    total++;
    spi_wr2(8'h14, 8'h80);
    spi_rd2(8'h94);
    if (rx_buf[1] !== 8'h00) begin $display("FAIL flush_level got=%h exp=00", rx_buf[1]); bad++; end
    total++;
    spi_rd2(8'h8C);
    if (rx_buf[1] !== 8'h00) begin $display("FAIL flush_flag got=%h exp=00", rx_buf[1]); bad++; end
    total++;
  endtask

  task automatic test_abort();
    logic [7:0] r;
    evt_cnt = 0;
    spi_cs_n = 1'b0;
    #80;
    if (spi_miso_oe !== 1'b1) begin $display("FAIL abort_oe got=%b exp=1", spi_miso_oe); bad++; end
    total++;
    spi_byte(8'h02, r);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = i[0];
      #80;
      spi_sck = 1'b1;
      #80;
      spi_sck = 1'b0;
    end
    #80;
    spi_cs_n = 1'b1;
    #160;
    if (evt_cnt !== 0) begin $display("FAIL abort_evt got=%0d exp=0", evt_cnt); bad++; end
    total++;
    spi_rd2(8'h82);
    if (rx_buf[1] !== 8'h11) begin $display("FAIL abort_reg01 got=%h exp=11", rx_buf[1]); bad++; end
    total++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic [7:0] d;
    spi_cs_n = 1'b0;
    #80;
    spi_byte(8'hEE, r);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b0;
      #80;
      spi_sck = 1'b1;
      #80;
      spi_sck = 1'b0;
    end
    #40;
    axi_areset = 1'b1;
    #1;
    if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
      $display("FAIL midreset_pins got=%b%b exp=00", spi_miso, spi_miso_oe); bad++;
    end
    total++;
    #9;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    #20;
    axi_areset = 1'b0;
    #100;
    host_read(6'h01, d);
    if (d !== 8'h00) begin $display("FAIL midreset_reg01 got=%h exp=00", d); bad++; end
    total++;
    host_read(6'h37, d);
    if (d !== 8'h92) begin $display("FAIL midreset_version got=%h exp=92", d); bad++; end
    total++;
    host_write(6'h05, 8'h3C);
    host_read(6'h05, d);
    if (d !== 8'h3C) begin $display("FAIL host_wr_rd got=%h exp=3c", d); bad++; end
    total++;
    host_write(6'h37, 8'h00);
    host_read(6'h37, d);
    if (d !== 8'h92) begin $display("FAIL host_wr_version got=%h exp=92", d); bad++; end
    total++;
    spi_rd2(8'h8A);
    if (rx_buf[1] !== 8'h3C) begin $display("FAIL spi_rd_hostreg got=%h exp=3c", rx_buf[1]); bad++; end
    total++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_version();
    test_burst();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
Synthesizable SPI mode-0 responder implementing the MFRC522 register-access protocol. It is the target end of the link driven by spi_axi_controller's SPI master. It holds a 64x8 register file, with a byte FIFO behind FIFODataReg. It replaces behavioural slave models in system benches and lets FPGA builds loop the SPI master back onto real logic.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_cs_n/spi_sck/spi_mosi
FIFO_DEPTH, 16, FIFODataReg depth in bytes (power of 2, 2..64)
VERSION, 8'h92, read-only value of VersionReg (0x37)

Ports:
axi_aclk  in  1  system clock; oversamples SPI (f_sck <= f_aclk/8)
axi_areset  in  1  asynchronous, active-high reset
spi_cs_n  in  1  chip select, active low
spi_sck  in  1  SPI clock, CPOL=0 CPHA=0
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  slave-out data, MSB first
spi_miso_oe  out  1  1 while spi_cs_n low (pad tristate enable)
host_addr  in  6  local-side register address
host_we  in  1  local-side write strobe
host_wdata  in  8  local-side write data
host_rdata  out  8  registered read of regs[host_addr], 1-cycle latency
evt_valid  out  1  1-cycle pulse per completed SPI write byte
evt_addr  out  6  address of that write
evt_data  out  8  data of that write

Behaviour:
- Reset (async, active-high): all regs 0x00, except 0x37=VERSION. FIFO empty. State IDLE. Outputs spi_miso=0, spi_miso_oe=0, host_rdata=0, evt_*=0.
- Inputs pass through SYNC_STAGES flops. SCK rise/fall and CS fall/rise are edge-detected on synchronized values. Everything runs in axi_aclk.
- Bit counter (3 bit) and 8-bit shift-in register sample MOSI on each SCK rise. A byte completes on the 8th rise.
- FSM IDLE -> ADDR on CS fall (bitcnt=0, miso shifter=0x00).
- Address byte format: bit7 = 1 read / 0 write; bits6:1 = address; bit0 ignored.
- ADDR byte complete:
  - write -> WDATA, latch address.
  - read -> RDATA: load shifter with read value of the address; first bit driven at the next SCK fall.
- WDATA byte complete: write regs[addr]. Address does NOT increment, so repeated bytes target the same register (FIFO burst). Pulse evt_* the cycle after.
- RDATA byte complete: the received byte is the next address byte. Load its read value; 0x00 is the terminating dummy byte and still reads address 0. Pops only occur on an actual load of 0x09.
- spi_miso changes only on SCK fall (shifter MSB). During the ADDR byte, miso=0.
- CS rise in any state: partial byte discarded, no write, no pop, -> IDLE, miso=0.
- Reset mid-transfer: immediate IDLE, register/FIFO contents reset.
- 0x09 FIFODataReg:
  - SPI write pushes.
  - SPI read-load pops.
  - Full push is dropped and sets regs[0x06] bit4 (BufferOvfl).
  - Empty pop returns 0x00 with no state change.
- 0x0A FIFOLevelReg: read returns {0, level[6:0]}. Write with bit7=1 flushes the FIFO and clears 0x06 bit4; other bits are ignored.
- 0x37 is read-only; writes to it are ignored.
- Host port: host_we writes regs[host_addr] (0x09/0x0A/0x37 excluded, ignored). If the SPI write and host write hit the same address in the same cycle, the SPI write wins.
- host_rdata for 0x09 returns the FIFO head without popping.

Decomposition:
- Package spi_slave_pkg: address constants (ERROR_REG=6'h06, FIFO_DATA=6'h09, FIFO_LEVEL=6'h0A, VERSION_REG=6'h37), BUFOVFL_BIT=4, FSM enum {IDLE, ADDR, WDATA, RDATA}.
- One sub-module spi_slv_fifo: synchronous byte FIFO with push/pop/flush/level/full/empty, using pointer wrap with an extra MSB.

Test Plan:
- Write 0x11 at addr 0x01 (MOSI 0x02,0x11), then read (0x82,0x00) -> MISO byte1 = 0x11; evt_valid once with addr=0x01, data=0x11.
- Read VersionReg (0xEE,0x00) -> MISO 0x92. Write 0x55 to 0x37, then re-read -> still 0x92.
- Burst write 0x12 then 0xA0,0xA1,0xA2; read 0x94 -> 0x03. Read 0x92,0x92,0x92,0x00 -> bytes 1..3 are 0xA0,0xA1,0xA2; level then 0.
- Push 17 bytes with FIFO_DEPTH=16 -> level 0x10, reg 0x06 = 0x10. Write 0x14,0x80 -> level 0 and 0x06 = 0x00.
- Deassert CS after 5 SCK cycles of a data byte to 0x01 -> reg 0x01 unchanged, no evt_valid. The next transaction decodes correctly.
- Assert axi_areset mid-read -> miso=0, miso_oe=0 immediately; all regs 0 except 0x37=0x92. Host write 0x3C to 0x05, then host_rdata at addr 0x05 = 0x3C one cycle later.
